// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: instruction sequencing FSM with a memory-wait
// watchdog that aborts stalled fetches or loads/stores back to FETCH.
module multicycle_control #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALU_Op,
  output logic       PC_write,
  output logic       IR_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       ALU_src_b,
  output logic       PC_src,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [3:0] {
    FETCH  = 4'd0, DECODE = 4'd1, ADDR   = 4'd2, MEM_RD = 4'd3, MEM_WR = 4'd4,
    WB_MEM = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7, WB_ALU = 4'd8, JUMP   = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q;
  logic            rdst_q, ill_q, merr_q;
  logic            is_r, is_lw, is_sw, is_ni, is_j, is_ill;
  logic            waiting, timeout_hit;

  assign is_r   = (opcode == 6'b000000);
  assign is_lw  = (opcode == 6'b100011);
  assign is_sw  = (opcode == 6'b101011);
  assign is_ni  = (opcode == 6'b001100);
  assign is_j   = (opcode == 6'b000010);
  assign is_ill = !(is_r || is_lw || is_sw || is_ni || is_j);

  assign waiting     = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  // Completion on the last allowed cycle wins over the abort.
  assign timeout_hit = waiting && !mem_ready && (wait_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (is_r)              state_d = EXEC_R;
        else if (is_lw || is_sw) state_d = ADDR;
        else if (is_ni)        state_d = EXEC_I;
        else if (is_j)         state_d = JUMP;
        else                   state_d = FETCH;
      end
      ADDR:   state_d = is_lw ? MEM_RD : MEM_WR;
      MEM_RD: if (mem_ready) state_d = WB_MEM;
              else if (timeout_hit) state_d = FETCH;
      MEM_WR: if (mem_ready || timeout_hit) state_d = FETCH;
      WB_MEM: state_d = FETCH;
      EXEC_R: state_d = WB_ALU;
      EXEC_I: state_d = WB_ALU;
      WB_ALU: state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q  <= '0;
      rdst_q  <= 1'b0;
      ill_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || timeout_hit) wait_q <= '0;
      else if (waiting && !mem_ready)        wait_q <= wait_q + 1'b1;
      if (state_q == EXEC_R)      rdst_q <= 1'b1;
      else if (state_q == EXEC_I) rdst_q <= 1'b0;
      ill_q   <= (state_q == DECODE) && is_ill;
      merr_q  <= timeout_hit;
    end
  end

  always_comb begin
    ALU_Op     = 2'b00;
    PC_write   = 1'b0;
    IR_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    ALU_src_b  = 1'b0;
    PC_src     = 1'b0;
    case (state_q)
      FETCH:  begin mem_read = 1'b1; IR_write = mem_ready; PC_write = mem_ready; end
      ADDR:   ALU_src_b = 1'b1;
      MEM_RD: mem_read = 1'b1;
      MEM_WR: mem_write = 1'b1;
      WB_MEM: begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      EXEC_R: ALU_Op = 2'b10;
      EXEC_I: begin ALU_Op = 2'b01; ALU_src_b = 1'b1; end
      WB_ALU: begin reg_write = 1'b1; reg_dst = rdst_q; end
      JUMP:   begin ALU_Op = 2'b11; PC_src = 1'b1; PC_write = 1'b1; end
      default: ;
    endcase
    // Architectural-state strobes are blocked immediately while in reset.
    if (rst) begin
      PC_write  = 1'b0;
      IR_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign illegal_op = ill_q;
  assign mem_err    = merr_q;
  assign state      = state_q;
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum memory wait cycles before abort.
REQ-002 SHALL have port clk  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port opcode  in  6  instruction opcode from IR.
REQ-005 SHALL have port mem_ready  in  1  memory handshake: current read or write completes this cycle.
REQ-006 SHALL have port ALU_Op  out  2  to ALU_control: 00 add, 01 nandi, 10 R-type, 11 jump.
REQ-007 SHALL have ports PC_write, IR_write, mem_read, mem_write, reg_write  out  1 each  datapath strobes.
REQ-008 SHALL have ports mem_to_reg, reg_dst, ALU_src_b, PC_src  out  1 each  datapath mux selects.
REQ-009 SHALL have ports illegal_op, mem_err  out  1 each  registered one-cycle error pulses.
REQ-010 SHALL have port state  out  4  current state encoding, for debug.

Function
REQ-011 SHALL decode opcodes: 000000 R-type, 100011 lw, 101011 sw, 001100 nandi, 000010 jump; all others illegal.
REQ-012 SHALL implement states FETCH=0, DECODE=1, ADDR=2, MEM_RD=3, MEM_WR=4, WB_MEM=5, EXEC_R=6, EXEC_I=7, WB_ALU=8, JUMP=9; codes 10-15 unreachable and SHALL go to FETCH.
REQ-013 FETCH SHALL drive mem_read=1 and ALU_Op=00, and SHALL stay in FETCH until mem_ready=1.
REQ-014 In FETCH with mem_ready=1, the block SHALL assert IR_write=1 and PC_write=1 in that same cycle (Mealy) and SHALL go to DECODE.
REQ-015 DECODE SHALL last one cycle and SHALL go to EXEC_R (R-type), ADDR (lw/sw), EXEC_I (nandi), JUMP (jump), or FETCH for an illegal opcode.
REQ-016 For an illegal opcode, illegal_op SHALL pulse high for exactly the cycle after DECODE.
REQ-017 ADDR SHALL drive ALU_Op=00 and ALU_src_b=1, then go to MEM_RD (lw) or MEM_WR (sw).
REQ-018 MEM_RD SHALL drive mem_read=1 and SHALL hold until mem_ready, then go to WB_MEM.
REQ-019 MEM_WR SHALL drive mem_write=1 and SHALL hold until mem_ready, then go to FETCH.
REQ-020 WB_MEM SHALL drive reg_write=1 and mem_to_reg=1 for one cycle, then go to FETCH.
REQ-021 EXEC_R SHALL drive ALU_Op=10 and ALU_src_b=0, then go to WB_ALU with reg_dst=1.
REQ-022 EXEC_I SHALL drive ALU_Op=01 and ALU_src_b=1, then go to WB_ALU with reg_dst=0.
REQ-023 WB_ALU SHALL drive reg_write=1 and mem_to_reg=0 for one cycle, then go to FETCH.
REQ-024 JUMP SHALL drive ALU_Op=11, PC_src=1 and PC_write=1 for one cycle, then go to FETCH.
REQ-025 Every output not named for a state SHALL be 0 in that state.
REQ-026 Instruction latency in cycles, with zero-wait memory (mem_ready=1 on first request cycle): R-type/nandi 4, lw 5, sw 4, jump 3.
REQ-027 A wait counter (width ceil(log2(TIMEOUT))+1) SHALL increment each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0, and SHALL clear on every state change.
REQ-028 When the wait counter reaches TIMEOUT-1 with mem_ready=0, the block SHALL go to FETCH, SHALL clear the counter, and SHALL pulse mem_err for one cycle; a timeout in FETCH re-enters FETCH.
REQ-029 If mem_ready=1 arrives in the same cycle the counter reaches TIMEOUT-1, the completion SHALL win and mem_err SHALL stay 0.
REQ-030 mem_ready SHALL be ignored in all states other than FETCH, MEM_RD and MEM_WR.

Reset
REQ-031 While rst=1, PC_write, IR_write, mem_write and reg_write SHALL be forced to 0 combinationally.
REQ-032 At a clock edge with rst=1, state SHALL become FETCH, the wait counter 0, and illegal_op and mem_err 0, regardless of the current state; a reset mid-instruction abandons that instruction.

Verification
REQ-033 Bench SHALL check: rst high 2 cycles during MEM_WR -> mem_write=0 while reset is high, state=0 after release, first cycle after release has mem_read=1.
REQ-034 Bench SHALL check: opcode=000000 with mem_ready always 1 -> states 0,1,6,8,0; ALU_Op=10 in EXEC_R; reg_write=1 and reg_dst=1 only in WB_ALU.
REQ-035 Bench SHALL check: lw with mem_ready delayed 3 cycles in MEM_RD -> state 3 held 4 cycles, then WB_MEM with reg_write=1 and mem_to_reg=1, mem_err=0.
REQ-036 Bench SHALL check: TIMEOUT=16, sw with mem_ready=0 forever -> after 16 cycles in MEM_WR, state=0 and mem_err pulses once.
REQ-037 Bench SHALL check: opcode=111111 -> states 0,1,0 and illegal_op=1 for exactly one cycle.
REQ-038 Bench SHALL check: opcode=000010 -> states 0,1,9,0; in JUMP, PC_write=1, PC_src=1 and ALU_Op=11.
